// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: length-prefixed big-endian image -> 32-bit imem writes.
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_loaded
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CSUM,
`endif
    FIN
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t POST_DATA = CSUM;
`else
  localparam state_t POST_DATA = FIN;
`endif

  state_t      state, nxt;
  logic [15:0] len;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] shreg;
  logic        xfer, word_done, last_word, in_range;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign xfer      = in_valid && in_ready;
  assign word_done = xfer && (state == DATA) && (byte_idx == 2'd3);
  assign last_word = (word_idx == len - 16'd1);
  assign in_range  = 32'(word_idx) < DEPTH;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt      = state;
    in_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) nxt = LEN_HI;
      end
      LEN_HI: begin
        in_ready = 1'b1;
        if (in_valid) nxt = LEN_LO;
      end
      LEN_LO: begin
        in_ready = 1'b1;
        if (in_valid) nxt = ({len[15:8], in_data} == 16'd0) ? POST_DATA : DATA;
      end
      DATA: begin
        in_ready = 1'b1;
        if (word_done && last_word) nxt = POST_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        in_ready = 1'b1;
        if (in_valid) nxt = FIN;
      end
`endif
      FIN: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
    cpu_hold = busy;
  end

  // mem_we is registered off the 4th byte, so the write lands one cycle later
  // while the next word's bytes keep flowing in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len          <= '0;
      word_idx     <= '0;
      byte_idx     <= '0;
      shreg        <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      err          <= 1'b0;
      words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: if (start) begin
          err          <= 1'b0;
          words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum         <= '0;
`endif
        end
        LEN_HI: if (xfer) len[15:8] <= in_data;
        LEN_LO: if (xfer) begin
          len[7:0] <= in_data;
          word_idx <= '0;
          byte_idx <= '0;
        end
        DATA: if (xfer) begin
          byte_idx <= byte_idx + 2'd1;
          shreg    <= {shreg[15:0], in_data};
          if (byte_idx == 2'd3) begin
            word_idx <= word_idx + 16'd1;
            if (in_range) begin
              mem_we    <= 1'b1;
              mem_addr  <= word_idx[ADDR_W-1:0];
              mem_wdata <= {shreg, in_data};
              if (32'(words_loaded) < DEPTH) words_loaded <= words_loaded + 16'd1;
            end else begin
              err <= 1'b1;
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: if (xfer && in_data != csum) err <= 1'b1;
`endif
        default: ;
      endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (xfer && state != CSUM) csum <= csum ^ in_data;
`endif
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: driver pushes expected writes/done/status checks,
// a negedge monitor pops and compares.
module tb_imem_loader;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int K_ZERO = 0, K_CLR = 1, K_RDY1 = 2, K_RDY0 = 3, K_TMO = 4, K_END = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_ready, mem_we, cpu_hold, busy, done, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [15:0]       words_loaded;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  typedef struct { int cyc; logic [ADDR_W-1:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int cyc; int words; logic err; } dn_t;
  typedef struct { int cyc; int kind; } ck_t;
  typedef logic [7:0] img_t [$];

  wr_t wq[$];
  dn_t dq[$];
  ck_t cq[$];
  int  tests = 0, fails = 0, cyc = 0;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic push_ck(input int kind);
    ck_t c;
    c.cyc = cyc; c.kind = kind;
    cq.push_back(c);
  endtask

  // Monitor: compares every DUT write/done against the queues and runs status checks.
  initial begin
    wr_t w; dn_t d; ck_t c; bit ok; bit post_done;
    post_done = 0;
    forever begin
      @(negedge clk);
      if (mem_we) begin
        tests++;
        if (wq.size() == 0) begin
          fails++;
          $display("FAIL write_unexpected cyc=%0d addr=%0d data=%h", cyc, mem_addr, mem_wdata);
        end else begin
          w = wq.pop_front();
          if (w.cyc != cyc || w.addr !== mem_addr || w.data !== mem_wdata) begin
            fails++;
            $display("FAIL write got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h",
                     cyc, mem_addr, mem_wdata, w.cyc, w.addr, w.data);
          end
        end
      end
      if (done) begin
        tests++;
        if (dq.size() == 0) begin
          fails++;
          $display("FAIL done_unexpected cyc=%0d", cyc);
        end else begin
          d = dq.pop_front();
          if (d.cyc != cyc || d.words != int'(words_loaded) || d.err !== err) begin
            fails++;
            $display("FAIL done got cyc=%0d words=%0d err=%b want cyc=%0d words=%0d err=%b",
                     cyc, words_loaded, err, d.cyc, d.words, d.err);
          end
        end
      end
      if (post_done) begin
        tests++;
        if (busy !== 1'b0 || cpu_hold !== 1'b0) begin
          fails++;
          $display("FAIL release_after_done busy=%b cpu_hold=%b want 0 0", busy, cpu_hold);
        end
      end
      post_done = done;
      while (cq.size() > 0 && cq[0].cyc <= cyc) begin
        c = cq.pop_front();
        tests++;
        case (c.kind)
          K_ZERO: ok = {mem_we, busy, cpu_hold, done, err, in_ready} == 6'b0 &&
                       mem_addr == '0 && mem_wdata == '0 && words_loaded == '0;
          K_CLR:  ok = err === 1'b0 && words_loaded === 16'd0 && busy === 1'b1 && cpu_hold === 1'b1;
          K_RDY1: ok = in_ready === 1'b1;
          K_RDY0: ok = in_ready === 1'b0;
          K_END:  ok = wq.size() == 0 && dq.size() == 0;
          default: ok = 0;
        endcase
        if (!ok)
          begin
            fails++;
            $display("FAIL check kind=%0d cyc=%0d we=%b busy=%b hold=%b done=%b err=%b rdy=%b words=%0d wq=%0d dq=%0d",
                     c.kind, cyc, mem_we, busy, cpu_hold, done, err, in_ready, words_loaded,
                     wq.size(), dq.size());
          end
      end
    end
  end

  // Driver + reference model. mode: 0 valid always, 1 toggling, 2 random gaps.
  // abort_n >= 0 asserts rst instead of sending byte abort_n.
  task automatic send_img(input img_t img_in, input int mode, input int abort_n, input bit bad);
    img_t img;
    int   n, t_xfer, w;
    logic [7:0] x;
    bit   e, tog, pres, sent;
    wr_t  wr;
    dn_t  dn;
    img = img_in;
`ifdef IMEM_LOADER_CHECKSUM_EN
    x = 8'h00;
    foreach (img[i]) x ^= img[i];
    img.push_back(x ^ {6'b0, bad, bad});
`endif
    n = int'({img[0], img[1]});
    e = n > DEPTH;
`ifdef IMEM_LOADER_CHECKSUM_EN
    x = 8'h00;
    for (int i = 0; i < img.size() - 1; i++) x ^= img[i];
    e = e || (x != img[img.size()-1]);
`else
    e = e || (bad && 1'b0);
`endif
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    push_ck(K_CLR);
    tog = 0;
    for (int i = 0; i < img.size(); i++) begin
      if (i == abort_n) begin
        in_valid = 1'b0;
        rst = 1'b1;
        push_ck(K_ZERO);
        @(posedge clk); #1 rst = 1'b0;
        push_ck(K_ZERO);
        return;
      end
      sent = 0;
      for (int t = 0; t < 64 && !sent; t++) begin
        pres = (mode == 0) || (mode == 1 && !tog) || (mode == 2 && $urandom_range(2) != 0);
        tog = !tog;
        in_valid = pres;
        in_data  = pres ? img[i] : 8'($urandom);
        push_ck(K_RDY1);
        if (pres && in_ready) begin
          sent = 1;
          t_xfer = cyc + 1;
          if (i >= 2 && i < 2 + 4*n && (i - 2) % 4 == 3) begin
            w = (i - 2) / 4;
            if (w < DEPTH) begin
              wr.cyc = t_xfer; wr.addr = w[ADDR_W-1:0];
              wr.data = {img[i-3], img[i-2], img[i-1], img[i]};
              wq.push_back(wr);
            end
          end
          if (i == img.size() - 1) begin
            dn.cyc = t_xfer; dn.words = (n < DEPTH) ? n : DEPTH; dn.err = e;
            dq.push_back(dn);
          end
        end
        @(posedge clk); #1;
      end
      if (!sent) push_ck(K_TMO);
    end
    in_valid = 1'b0;
    push_ck(K_RDY0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic rand_img(input int n, output img_t img);
    img = {};
    img.push_back(8'(n >> 8));
    img.push_back(8'(n));
    for (int i = 0; i < 4*n; i++) img.push_back(8'($urandom));
  endtask

  initial begin
    img_t img, prog;
    prog = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h24, 8'h09, 8'h00, 8'h07};
    @(posedge clk); #1 push_ck(K_ZERO);
    @(posedge clk); #1 rst = 1'b0;
    // rst and start together: rst wins
    @(posedge clk); #1 rst = 1'b1; start = 1'b1;
    push_ck(K_ZERO);
    @(posedge clk); #1 rst = 1'b0; start = 1'b0;
    push_ck(K_ZERO);
    @(posedge clk); #1;

    send_img(prog, 0, -1, 0);
    send_img(prog, 1, -1, 0);
    img = '{8'h00, 8'h00};
    send_img(img, 0, -1, 0);
    rand_img(5, img);
    send_img(img, 0, -1, 0);
    rand_img(3, img);
    send_img(img, 2, 8, 0);
    send_img(prog, 0, -1, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    img = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    send_img(img, 0, -1, 0);
    send_img(img, 0, -1, 1);
`endif
    for (int k = 0; k < 12; k++) begin
      rand_img(int'($urandom_range(6)), img);
      send_img(img, int'($urandom_range(2)), -1, bit'($urandom_range(1)));
    end
    @(posedge clk); #1 push_ck(K_END);
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream writer that fills the instruction memory the core fetches from.
- Receives a length-prefixed, big-endian program image over a valid/ready byte interface and assembles it into 32-bit words.
- Drives the instruction memory write port and holds the core in reset while loading is in progress.
- Sits between the host/UART byte source and the imem write port; the core's fetch path (pc -> imem read) is untouched.

Parameters:
- ADDR_W, 8, word-address width of imem; DEPTH = 2**ADDR_W words.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle request to begin a load; ignored while busy
- in_valid  in  1  in_data holds a byte
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  imem write enable, one-cycle pulse per word
- mem_addr  out  ADDR_W  imem word address
- mem_wdata  out  32  imem write data
- cpu_hold  out  1  high keeps the core in reset
- busy  out  1  load in progress
- done  out  1  one-cycle pulse at load completion
- err  out  1  sticky error flag, cleared by the next accepted start
- words_loaded  out  16  count of words actually written

Behaviour:
- Reset (async): state IDLE; all outputs 0; internal byte index, shift register and word counter cleared.
- Byte transfer occurs on any cycle with in_valid && in_ready. in_ready depends only on state, never on in_valid.
- States:
  - IDLE: in_ready=0, busy=0, cpu_hold=0. On start: clear err and words_loaded; go to LEN_HI.
  - LEN_HI: in_ready=1. On transfer: N[15:8] <= byte; go to LEN_LO.
  - LEN_LO: in_ready=1. On transfer: N[7:0] <= byte. If N==0, go to FIN; otherwise go to DATA with word index 0 and byte index 0.
  - DATA: in_ready=1. Each transfer shifts the byte in MSB-first (first byte -> wdata[31:24]).
    - On the 4th byte of a word, if word index < DEPTH: the next cycle drives mem_we=1, mem_addr=word index[ADDR_W-1:0], mem_wdata=assembled word, and words_loaded increments in that same cycle.
    - If word index >= DEPTH: no write; err <= 1; the bytes are still consumed.
    - After word N-1 completes, go to FIN.
  - FIN: in_ready=0. Lasts one cycle. In that cycle the final mem_we (if any) is issued, and done=1. Then go to IDLE.
- busy=1 and cpu_hold=1 in every state except IDLE. They drop in the cycle after FIN, i.e. the cycle after done.
- Write latency: mem_we is exactly one cycle after the transfer of the 4th byte. Byte acceptance continues during that write cycle (no bubble).
- mem_addr and mem_wdata hold their last values when mem_we=0.
- start is ignored outside IDLE. start and rst asserted together: rst wins.
- Reset mid-load: the partial word is discarded and no write is issued. Words already written stay in imem; words_loaded is cleared.
- words_loaded saturates at DEPTH.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the data (or directly after LEN_LO when N==0), state CSUM accepts exactly one extra byte; FIN follows it.
  - Expected value is the XOR of both length bytes and all data bytes.
  - A mismatch sets err=1. Words already written are kept.
- Not defined: there is no CSUM state and no checksum byte; the stream ends after the last data byte.

Test Plan:
1. Stream 00 02 24 08 00 05 24 09 00 07 with in_valid held high after start:
   - mem_we at addr 0 with 0x24080005, then at addr 1 with 0x24090007, each one cycle after the 4th byte of its word.
   - done pulses once; words_loaded=2; err=0; cpu_hold falls the cycle after done.
2. Same image with in_valid toggling every other cycle:
   - Identical writes and data; no byte lost or duplicated; in_ready stays 1 through DATA.
3. Length 00 00:
   - No mem_we; done in the cycle after LEN_LO; words_loaded=0; err=0.
4. ADDR_W=2, length 00 05, 20 data bytes:
   - Writes to addrs 0..3 only; 5th word consumed without a write; err=1; words_loaded=4.
   - A later start clears err.
5. rst pulse after 6 data bytes:
   - All outputs 0 immediately; no write for the partial word.
   - A fresh load afterwards from addr 0 succeeds.
6. (IMEM_LOADER_CHECKSUM_EN) Stream 00 01 12 34 56 78 followed by checksum 0x09 (00^01^12^34^56^78):
   - err=0. The same stream with checksum 0x0A gives err=1, and the word 0x12345678 is still written to addr 0.
